// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds PC and MAR, fetches a 24-bit instruction as three bytes over a
// req/ack port, and updates command_word atomically. Optional build macro: FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int ADDR_W         = 8,
  parameter int RESET_PC       = 0,
  parameter int PC_STEP        = 3,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_load_en,
  input  logic [ADDR_W-1:0] PC_load,
  input  logic              PC_inc,
  input  logic              MAR_load,
  input  logic              IR_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [23:0]       command_word,
  output logic              ir_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mar;
  logic              ir_load_q;
  logic [23:0]       shadow;
  logic              start;
  logic              abort;

  assign start = IR_load && !ir_load_q;

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = '0;
    case (state)
      S_IDLE: if (start) state_nxt = S_B0;
      S_B0: begin
        mem_req  = 1'b1;
        mem_addr = mar;
        if (mem_ack) state_nxt = S_B1;
      end
      S_B1: begin
        mem_req  = 1'b1;
        mem_addr = mar + ADDR_W'(1);
        if (mem_ack) state_nxt = S_B2;
      end
      S_B2: begin
        mem_req  = 1'b1;
        mem_addr = mar + ADDR_W'(2);
        if (mem_ack) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= ADDR_W'(RESET_PC);
      mar          <= '0;
      ir_load_q    <= 1'b0;
      command_word <= '0;
      ir_valid     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state     <= state_nxt;
      ir_load_q <= IR_load;
      if (pc_load_en)  pc <= PC_load;
      else if (PC_inc) pc <= pc + ADDR_W'(PC_STEP);
      // MAR sees the PC from before any same-cycle PC update
      if (MAR_load && !busy) mar <= pc;
      if (state == S_IDLE && start) begin
        busy     <= 1'b1;
        ir_valid <= 1'b0;
      end
      if (state == S_DONE) begin
        command_word <= shadow;
        ir_valid     <= 1'b1;
        busy         <= 1'b0;
      end
      if (abort) busy <= 1'b0;
    end
  end

  // Bytes assemble here so command_word only ever changes as a whole instruction
  always_ff @(posedge clk) begin
    if (mem_req && mem_ack) begin
      case (state)
        S_B0:    shadow[7:0]   <= mem_rdata;
        S_B1:    shadow[15:8]  <= mem_rdata;
        S_B2:    shadow[23:16] <= mem_rdata;
        default: ;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             fetch_err_q;

  assign abort     = mem_req && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fetch_err = fetch_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      if (!mem_req || mem_ack || abort) wait_cnt <= '0;
      else                              wait_cnt <= wait_cnt + CNT_W'(1);
      if (abort) fetch_err_q <= 1'b1;
    end
  end
`else
  assign abort     = 1'b0;
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: random memory, random wait states, reference PC/MAR model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_load_en = 1'b0;
  logic [7:0]  PC_load = '0;
  logic        PC_inc = 1'b0;
  logic        MAR_load = 1'b0;
  logic        IR_load = 1'b0;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [23:0] command_word;
  logic        ir_valid;
  logic        busy;
  logic [7:0]  pc;
  logic        fetch_err;

  instr_fetch_unit #(
    .ADDR_W(8), .RESET_PC(0), .PC_STEP(3), .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk), .rst(rst), .pc_load_en(pc_load_en), .PC_load(PC_load), .PC_inc(PC_inc),
    .MAR_load(MAR_load), .IR_load(IR_load), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .command_word(command_word),
    .ir_valid(ir_valid), .busy(busy), .pc(pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] cw;
    int          done;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  addr_q[$];
  logic [7:0]  mem [256];
  int          wait_cfg = 0;
  bit          noise_en = 1'b0;
  int          n_checks = 0;
  int          n_errs = 0;
  logic [23:0] cur_cw = '0;
  logic [7:0]  m_pc = '0;
  logic [7:0]  m_mar = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: ack after wait_cfg cycles of request, random ack noise while idle
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (wcnt < wait_cfg) begin
          mem_ack = 1'b0;
          wcnt++;
        end else begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          wcnt      = 0;
          if (addr_q.size() == 0) check("unexpected_mem_req", 32'(mem_addr), 32'hFFFF);
          else check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
        end
      end else begin
        wcnt      = 0;
        mem_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Monitor: completed instructions against the scoreboard, IR held steady otherwise
  initial begin
    exp_t e;
    bit   iv_prev;
    iv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ir_valid && !iv_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ir_valid", 32'(ir_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("command_word", 32'(command_word), 32'(e.cw));
          check("fetch_latency", 32'(cyc), 32'(e.done));
          cur_cw = e.cw;
        end
      end else begin
        check("ir_hold", 32'(command_word), 32'(cur_cw));
      end
      iv_prev = ir_valid;
    end
  end

  task automatic op(input bit ple, input logic [7:0] pl, input bit inc, input bit marl);
    pc_load_en = ple;
    PC_load    = pl;
    PC_inc     = inc;
    MAR_load   = marl;
    if (marl) m_mar = m_pc;
    if (ple) m_pc = pl;
    else if (inc) m_pc = m_pc + 8'd3;
    @(negedge clk);
    pc_load_en = 1'b0;
    PC_inc     = 1'b0;
    MAR_load   = 1'b0;
    check("pc_update", 32'(pc), 32'(m_pc));
  endtask

  // Start a fetch at m_mar; optional disturbances at negedge index i after the start
  task automatic fetch(input int w, input int hold_len, input int pulse_at, input int marl_at,
                       input int inc_at);
    exp_t       e;
    int         d;
    int         len;
    logic [7:0] a0, a1, a2;
    a0 = m_mar;
    a1 = m_mar + 8'd1;
    a2 = m_mar + 8'd2;
    addr_q.push_back(a0);
    addr_q.push_back(a1);
    addr_q.push_back(a2);
    d      = 3 * (w + 1) + 1;
    e.cw   = {mem[a2], mem[a1], mem[a0]};
    e.done = cyc + 1 + d;
    exp_q.push_back(e);
    wait_cfg = w;
    IR_load  = 1'b1;
    len = ((hold_len > d + 1) ? hold_len : d + 1) + 3;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      IR_load  = (i < hold_len) || (i == pulse_at);
      MAR_load = (i == marl_at);
      PC_inc   = (i == inc_at);
      if (i == inc_at) m_pc = m_pc + 8'd3;
      if (i > d) check("busy_after_fetch", 32'(busy), 32'd0);
    end
    IR_load  = 1'b0;
    MAR_load = 1'b0;
    PC_inc   = 1'b0;
    check("fetch_completed", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("pc_after_fetch", 32'(pc), 32'(m_pc));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required < 300000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_cw", 32'(command_word), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);

    // Basic fetch from address 0
    mem[0] = 8'h03;
    mem[1] = 8'h12;
    mem[2] = 8'h34;
    op(1'b0, 8'h00, 1'b0, 1'b1);
    fetch(0, 1, 0, 0, 0);
    check("basic_cw", 32'(command_word), 32'h341203);
    check("basic_ir_valid", 32'(ir_valid), 32'd1);

    // PC priority and MAR capturing the pre-update PC
    op(1'b1, 8'h10, 1'b0, 1'b0);
    op(1'b1, 8'h40, 1'b1, 1'b1);
    check("prio_load", 32'(pc), 32'h40);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    check("prio_inc", 32'(pc), 32'h43);
    fetch(0, 1, 0, 0, 0);

    // Address wrap-around
    noise_en = 1'b1;
    op(1'b1, 8'hFE, 1'b0, 1'b0);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    fetch(0, 1, 0, 0, 0);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_pc", 32'(pc), 32'h01);

    // Wait states, held IR_load, mid-fetch pulse and MAR_load
    op(1'b1, 8'h80, 1'b0, 1'b0);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    fetch(2, 14, 0, 3, 2);
    fetch(1, 1, 3, 4, 0);
    fetch(0, 1, 0, 0, 0);

    // Randomized fetches
    for (int t = 0; t < 10; t++) begin
      op(1'b1, 8'($urandom), 1'b0, 1'b0);
      op(1'b0, 8'h00, 1'b0, 1'b1);
      mem[m_mar]         = 8'($urandom);
      mem[m_mar + 8'd1]  = 8'($urandom);
      fetch(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 0, 0,
            int'($urandom_range(0, 4)));
    end

`ifdef FETCH_TIMEOUT_EN
    // Ack never arrives in B0: abort after 15 waiting cycles, IR retained
    begin
      logic [23:0] prev_cw;
      prev_cw  = command_word;
      noise_en = 1'b0;
      wait_cfg = 100000;
      IR_load  = 1'b1;
      for (int i = 1; i <= 18; i++) begin
        @(negedge clk);
        IR_load = 1'b0;
        if (i == 15) check("to_req_before", 32'(mem_req), 32'd1);
        if (i == 16) begin
          check("to_req_after", 32'(mem_req), 32'd0);
          check("to_busy", 32'(busy), 32'd0);
          check("to_fetch_err", 32'(fetch_err), 32'd1);
          check("to_ir_valid", 32'(ir_valid), 32'd0);
          check("to_cw", 32'(command_word), 32'(prev_cw));
        end
      end
      wait_cfg = 0;
      fetch(0, 1, 0, 0, 0);
      check("to_err_sticky", 32'(fetch_err), 32'd1);
    end
`else
    check("no_fetch_err", 32'(fetch_err), 32'd0);
`endif

    // Reset asserted during B1
    noise_en = 1'b0;
    wait_cfg = 0;
    op(1'b1, 8'h55, 1'b0, 1'b0);
    addr_q.push_back(m_mar);
    addr_q.push_back(m_mar + 8'd1);
    IR_load = 1'b1;
    @(negedge clk);
    IR_load = 1'b0;
    @(negedge clk);
    #2;
    rst    = 1'b1;
    cur_cw = '0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_cw", 32'(command_word), 32'd0);
    check("arst_ir_valid", 32'(ir_valid), 32'd0);
    check("arst_pc", 32'(pc), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_fetch_err", 32'(fetch_err), 32'd0);
    addr_q.delete();
    exp_q.delete();
    m_pc  = '0;
    m_mar = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_req", 32'(mem_req), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    fetch(1, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
